// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, ALU codes, FSM states.
// Imported by core_sequencer and imm_gen.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: is_legal_op = 1'b1;
            default:                                       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J layout from the opcode and sign-extends to 32 bits.
module imm_gen
    import core_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (ir_i[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
            OP_STORE:
                imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            OP_BRANCH:
                imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_o = {ir_i[31:12], 12'b0};
            OP_JAL:
                imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, write-back, one instruction at a time.
// Define CORE_SEQ_MISALIGN_TRAP_EN to halt on misaligned data/branch addresses instead of masking them.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        res_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [4:0]  rf_raddr_a_o,
    output logic [4:0]  rf_raddr_b_o,
    input  logic [31:0] rf_rdata_a_i,
    input  logic [31:0] rf_rdata_b_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_result_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        retire_o,
    output logic        halt_o,
    output logic        illegal_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] r_q, r_d;
    logic [31:0] ld_q, ld_d;
    logic        taken_q, taken_d;
    logic        illegal_q, illegal_d;

    logic [31:0] imm_dec;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        branch_cond;
    logic        is_jump;
    logic        writes_rd;
    logic        redirect;
    logic [31:0] target;

    imm_gen u_imm_gen (
        .ir_i  (ir_q),
        .imm_o (imm_dec)
    );

    assign opcode    = ir_q[6:0];
    assign rd        = ir_q[11:7];
    assign funct3    = ir_q[14:12];
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign writes_rd = (opcode == OP_R)    || (opcode == OP_IMM)   || (opcode == OP_LOAD) ||
                       (opcode == OP_LUI)  || (opcode == OP_AUIPC) || is_jump;
    assign redirect  = is_jump || ((opcode == OP_BRANCH) && taken_q);

`ifdef CORE_SEQ_MISALIGN_TRAP_EN
    assign target = r_q;
`else
    assign target = {r_q[31:2], 2'b00};
`endif

    // Branch comparator runs on the latched operands, independent of the external ALU.
    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            3'b000:  branch_cond = (a_q == b_q);
            3'b001:  branch_cond = (a_q != b_q);
            3'b100:  branch_cond = ($signed(a_q) <  $signed(b_q));
            3'b101:  branch_cond = ($signed(a_q) >= $signed(b_q));
            3'b110:  branch_cond = (a_q <  b_q);
            3'b111:  branch_cond = (a_q >= b_q);
            default: branch_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            r_q       <= '0;
            ld_q      <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            r_q       <= r_d;
            ld_q      <= ld_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    // While res_i is high every output is held at its idle value; the FSM itself resets on the edge.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        imm_d        = imm_q;
        r_d          = r_q;
        ld_d         = ld_q;
        taken_d      = taken_q;
        illegal_d    = illegal_q;
        imem_req_o   = 1'b0;
        imem_addr_o  = '0;
        rf_raddr_a_o = '0;
        rf_raddr_b_o = '0;
        rf_we_o      = 1'b0;
        rf_waddr_o   = '0;
        rf_wdata_o   = '0;
        alu_ctrl_o   = ALU_ADD;
        alu_a_o      = '0;
        alu_b_o      = '0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        retire_o     = 1'b0;

        if (!res_i) begin
            case (state_q)
                FETCH: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = pc_q;
                    if (imem_rvalid_i) begin
                        ir_d    = imem_rdata_i;
                        state_d = DECODE;
                    end
                end

                DECODE: begin
                    rf_raddr_a_o = ir_q[19:15];
                    rf_raddr_b_o = ir_q[24:20];
                    a_d          = rf_rdata_a_i;
                    b_d          = rf_rdata_b_i;
                    imm_d        = imm_dec;
                    if (!is_legal_op(opcode)) begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end else if (opcode == OP_SYSTEM) begin
                        state_d = HALT;
                    end else begin
                        state_d = EXEC;
                    end
                end

                EXEC: begin
                    case (opcode)
                        OP_R: begin
                            alu_ctrl_o = {ir_q[30], funct3};
                            alu_a_o    = a_q;
                            alu_b_o    = b_q;
                        end
                        OP_IMM: begin
                            alu_ctrl_o = (funct3 == 3'b101) ? {ir_q[30], funct3} : {1'b0, funct3};
                            alu_a_o    = a_q;
                            alu_b_o    = imm_q;
                        end
                        OP_LOAD, OP_STORE, OP_JALR: begin
                            alu_a_o = a_q;
                            alu_b_o = imm_q;
                        end
                        OP_JAL, OP_AUIPC, OP_BRANCH: begin
                            alu_a_o = pc_q;
                            alu_b_o = imm_q;
                        end
                        default: begin
                            alu_a_o = '0;
                            alu_b_o = imm_q;
                        end
                    endcase
                    r_d     = (opcode == OP_JALR) ? (alu_result_i & ~32'h1) : alu_result_i;
                    taken_d = branch_cond;
                    if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                        state_d = MEM;
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
                        if (alu_result_i[1:0] != 2'b00) begin
                            illegal_d = 1'b1;
                            state_d   = HALT;
                        end
`endif
                    end else begin
                        state_d = WB;
                    end
                end

                MEM: begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = (opcode == OP_STORE);
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
                    dmem_addr_o  = r_q;
`else
                    dmem_addr_o  = {r_q[31:2], 2'b00};
`endif
                    dmem_wdata_o = b_q;
                    if (dmem_rvalid_i) begin
                        if (opcode == OP_LOAD) begin
                            ld_d = dmem_rdata_i;
                        end
                        state_d = WB;
                    end
                end

                WB: begin
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
                    if (redirect && (target[1:0] != 2'b00)) begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end else
`endif
                    begin
                        rf_we_o    = writes_rd && (rd != 5'd0);
                        rf_waddr_o = rd;
                        if (opcode == OP_LOAD) begin
                            rf_wdata_o = ld_q;
                        end else if (is_jump) begin
                            rf_wdata_o = pc_q + 32'd4;
                        end else begin
                            rf_wdata_o = r_q;
                        end
                        pc_d     = redirect ? target : (pc_q + 32'd4);
                        retire_o = 1'b1;
                        state_d  = FETCH;
                    end
                end

                HALT: begin
                    state_d = HALT;
                end

                default: begin
                    state_d = HALT;
                end
            endcase
        end
    end

    assign halt_o    = !res_i && (state_q == HALT);
    assign illegal_o = !res_i && illegal_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: small program with hand-computed results, memory and RF/ALU models.
module tb_core_sequencer;

    logic        clk_i = 1'b0;
    logic        res_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [4:0]  rf_raddr_a_o;
    logic [4:0]  rf_raddr_b_o;
    logic [31:0] rf_rdata_a_i;
    logic [31:0] rf_rdata_b_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        retire_o;
    logic        halt_o;
    logic        illegal_o;

    int n_cmp = 0;
    int n_bad = 0;
    int imem_wait = 0;
    int dmem_wait = 0;
    int imem_cnt = 0;
    int dmem_cnt = 0;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic [31:0] rf   [32];

    always #5 clk_i = ~clk_i;

    core_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i         (clk_i),
        .res_i         (res_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .rf_raddr_a_o  (rf_raddr_a_o),
        .rf_raddr_b_o  (rf_raddr_b_o),
        .rf_rdata_a_i  (rf_rdata_a_i),
        .rf_rdata_b_i  (rf_rdata_b_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .alu_ctrl_o    (alu_ctrl_o),
        .alu_a_o       (alu_a_o),
        .alu_b_o       (alu_b_o),
        .alu_result_i  (alu_result_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .retire_o      (retire_o),
        .halt_o        (halt_o),
        .illegal_o     (illegal_o)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: alu_model = a + b;
            4'b1000: alu_model = a - b;
            4'b0001: alu_model = a << b[4:0];
            4'b0010: alu_model = {31'b0, $signed(a) < $signed(b)};
            4'b0011: alu_model = {31'b0, a < b};
            4'b0100: alu_model = a ^ b;
            4'b0101: alu_model = a >> b[4:0];
            4'b1101: alu_model = $unsigned($signed(a) >>> b[4:0]);
            4'b0110: alu_model = a | b;
            4'b0111: alu_model = a & b;
            default: alu_model = 32'h0;
        endcase
    endfunction

    // Memories answer after a programmable number of request cycles; zero means same-cycle rvalid.
    assign imem_rvalid_i = imem_req_o && (imem_cnt == imem_wait);
    assign imem_rdata_i  = imem[imem_addr_o[9:2]];
    assign dmem_rvalid_i = dmem_req_o && (dmem_cnt == dmem_wait);
    assign dmem_rdata_i  = dmem[dmem_addr_o[9:2]];
    assign rf_rdata_a_i  = (rf_raddr_a_o == 5'd0) ? 32'h0 : rf[rf_raddr_a_o];
    assign rf_rdata_b_i  = (rf_raddr_b_o == 5'd0) ? 32'h0 : rf[rf_raddr_b_o];
    assign alu_result_i  = alu_model(alu_ctrl_o, alu_a_o, alu_b_o);

    always @(posedge clk_i) begin
        if (imem_req_o && !imem_rvalid_i) imem_cnt <= imem_cnt + 1;
        else                              imem_cnt <= 0;
        if (dmem_req_o && !dmem_rvalid_i) dmem_cnt <= dmem_cnt + 1;
        else                              dmem_cnt <= 0;
        if (dmem_req_o && dmem_rvalid_i && dmem_we_o) dmem[dmem_addr_o[9:2]] <= dmem_wdata_o;
        if (rf_we_o) rf[rf_waddr_o] <= rf_wdata_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        res_i = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({imem_req_o, dmem_req_o, rf_we_o, dmem_we_o, retire_o, halt_o, illegal_o} !== 7'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_strobes: got %b want 0000000", {imem_req_o, dmem_req_o, rf_we_o, dmem_we_o, retire_o, halt_o, illegal_o});
        end
        n_cmp++;
        if (imem_addr_o !== 32'h0 || dmem_addr_o !== 32'h0 || rf_wdata_o !== 32'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_addr: imem %h dmem %h wdata %h want all 0", imem_addr_o, dmem_addr_o, rf_wdata_o);
        end
        res_i = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            n_bad++;
            $display("[TB] FAIL first_fetch: req %b addr %h want 1 00000100", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_addi();
        tick(); tick(); tick();
        n_cmp++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'd5 || retire_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL addi_wb: we %b rd %0d data %h retire %b want 1 1 5 1", rf_we_o, rf_waddr_o, rf_wdata_o, retire_o);
        end
        tick();
        n_cmp++;
        if (imem_addr_o !== 32'h104 || retire_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL addi_pc: addr %h retire %b want 00000104 0", imem_addr_o, retire_o);
        end
    endtask

    task automatic test_x0_write();
        tick(); tick();
        n_cmp++;
        if (alu_ctrl_o !== 4'b0000 || alu_a_o !== 32'd5 || alu_b_o !== 32'd5) begin
            n_bad++;
            $display("[TB] FAIL add_exec: ctrl %b a %h b %h want 0000 5 5", alu_ctrl_o, alu_a_o, alu_b_o);
        end
        tick();
        n_cmp++;
        if (rf_we_o !== 1'b0 || retire_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL add_x0_wb: we %b retire %b want 0 1", rf_we_o, retire_o);
        end
        tick();
        n_cmp++;
        if (imem_addr_o !== 32'h108) begin
            n_bad++;
            $display("[TB] FAIL add_pc: got %h want 00000108", imem_addr_o);
        end
    endtask

    task automatic test_branch();
        int n;
        imem_wait = 2;
        n = 1;
        while (retire_o !== 1'b1 && n < 30) begin tick(); n++; end
        n_cmp++;
        if (n != 6) begin
            n_bad++;
            $display("[TB] FAIL beq_cycles: got %0d want 6", n);
        end
        imem_wait = 0;
        tick();
        n_cmp++;
        if (imem_addr_o !== 32'h110) begin
            n_bad++;
            $display("[TB] FAIL beq_target: got %h want 00000110", imem_addr_o);
        end
        n = 1;
        while (retire_o !== 1'b1 && n < 30) begin tick(); n++; end
        n_cmp++;
        if (n != 4) begin
            n_bad++;
            $display("[TB] FAIL bne_cycles: got %0d want 4", n);
        end
        tick();
        n_cmp++;
        if (imem_addr_o !== 32'h114) begin
            n_bad++;
            $display("[TB] FAIL bne_fallthrough: got %h want 00000114", imem_addr_o);
        end
    endtask

    task automatic test_store_load();
        int n;
        tick(); tick(); tick();
        n_cmp++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd2 || rf_wdata_o !== 32'h200) begin
            n_bad++;
            $display("[TB] FAIL addi_x2: we %b rd %0d data %h want 1 2 00000200", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        dmem_wait = 2;
        tick();
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== 32'h204 || dmem_wdata_o !== 32'd5) begin
                n_bad++;
                $display("[TB] FAIL sw_mem%0d: req %b we %b addr %h data %h want 1 1 00000204 5", i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o);
            end
            tick();
        end
        n_cmp++;
        if (retire_o !== 1'b1 || rf_we_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL sw_wb: retire %b we %b want 1 0", retire_o, rf_we_o);
        end
        dmem_wait = 0;
        tick();
        n = 1;
        while (retire_o !== 1'b1 && n < 30) begin tick(); n++; end
        n_cmp++;
        if (n != 5 || rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'd5) begin
            n_bad++;
            $display("[TB] FAIL lw_wb: cycles %0d we %b rd %0d data %h want 5 1 3 5", n, rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
    endtask

    task automatic test_jal();
        int n;
        n = 1;
        while (retire_o !== 1'b1 && n < 30) begin tick(); n++; end
        n_cmp++;
        if (n != 4 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h124) begin
            n_bad++;
            $display("[TB] FAIL jal_link: cycles %0d rd %0d data %h want 4 5 00000124", n, rf_waddr_o, rf_wdata_o);
        end
        tick();
        n_cmp++;
        if (imem_addr_o !== 32'h128) begin
            n_bad++;
            $display("[TB] FAIL jal_target: got %h want 00000128", imem_addr_o);
        end
    endtask

    task automatic test_illegal();
        tick();
        n_cmp++;
        if (halt_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL illegal_decode_halt: got %b want 0", halt_o);
        end
        tick();
        n_cmp++;
        if (halt_o !== 1'b1 || illegal_o !== 1'b1 || imem_req_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL illegal_halt: halt %b illegal %b req %b want 1 1 0", halt_o, illegal_o, imem_req_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (imem_req_o !== 1'b0 || dmem_req_o !== 1'b0 || retire_o !== 1'b0 || halt_o !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL halt_idle%0d: ireq %b dreq %b retire %b halt %b want 0 0 0 1", i, imem_req_o, dmem_req_o, retire_o, halt_o);
            end
        end
    endtask

    task automatic test_ecall();
        imem[64] = 32'h0000_0073;
        res_i = 1'b1;
        tick();
        res_i = 1'b0;
        #1;
        tick();
        tick();
        n_cmp++;
        if (halt_o !== 1'b1 || illegal_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ecall_halt: halt %b illegal %b want 1 0", halt_o, illegal_o);
        end
    endtask

    task automatic test_reset_mid_access();
        imem[64] = 32'h0011_2223;
        dmem_wait = 10;
        res_i = 1'b1;
        tick();
        res_i = 1'b0;
        #1;
        tick(); tick(); tick();
        tick();
        n_cmp++;
        if (dmem_req_o !== 1'b1 || halt_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mid_wait_req: req %b halt %b want 1 0", dmem_req_o, halt_o);
        end
        res_i = 1'b1;
        tick();
        n_cmp++;
        if (dmem_req_o !== 1'b0 || imem_req_o !== 1'b0 || halt_o !== 1'b0 || retire_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mid_reset_clear: dreq %b ireq %b halt %b retire %b want 0 0 0 0", dmem_req_o, imem_req_o, halt_o, retire_o);
        end
        res_i = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || dmem_req_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mid_reset_refetch: ireq %b addr %h dreq %b want 1 00000100 0", imem_req_o, imem_addr_o, dmem_req_o);
        end
        dmem_wait = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0000_0013;
            dmem[i] = 32'h0;
        end
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        imem[64] = 32'h0050_0093;   // 0x100 addi x1,x0,5
        imem[65] = 32'h0010_8033;   // 0x104 add  x0,x1,x1
        imem[66] = 32'h0010_8463;   // 0x108 beq  x1,x1,+8
        imem[68] = 32'h0010_9463;   // 0x110 bne  x1,x1,+8
        imem[69] = 32'h2000_0113;   // 0x114 addi x2,x0,0x200
        imem[70] = 32'h0011_2223;   // 0x118 sw   x1,4(x2)
        imem[71] = 32'h0041_2183;   // 0x11c lw   x3,4(x2)
        imem[72] = 32'h0080_02EF;   // 0x120 jal  x5,+8
        imem[74] = 32'h0000_007F;   // 0x128 illegal opcode

        test_reset();
        test_addi();
        test_x0_write();
        test_branch();
        test_store_load();
        test_jal();
        test_illegal();
        test_ecall();
        test_reset_mid_access();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. It fetches each instruction over a request/valid handshake, decodes it, and drives the register-file ports, ALU control and operands, and data-memory port, one instruction at a time. It owns the PC and sits between the instruction/data memories and the existing combinational ALU and register file. Word-only loads and stores; no CSR support.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- res_i  in  1  synchronous, active-high reset
- imem_req_o  out  1  instruction fetch request, held until imem_rvalid_i
- imem_addr_o  out  32  fetch address (= PC)
- imem_rvalid_i  in  1  instruction data valid
- imem_rdata_i  in  32  instruction word
- rf_raddr_a_o / rf_raddr_b_o  out  5 each  rs1 / rs2 read addresses
- rf_rdata_a_i / rf_rdata_b_i  in  32 each  combinational read data
- rf_we_o  out  1  register write strobe, one cycle
- rf_waddr_o  out  5  rd
- rf_wdata_o  out  32  write data
- alu_ctrl_o  out  4  ALU opcode
- alu_a_o / alu_b_o  out  32 each  ALU operands
- alu_result_i  in  32  ALU result
- dmem_req_o  out  1  data request, held until dmem_rvalid_i
- dmem_we_o  out  1  1 = store
- dmem_addr_o / dmem_wdata_o  out  32 each  address / store data
- dmem_rvalid_i  in  1  access complete (load data valid)
- dmem_rdata_i  in  32  load data
- retire_o  out  1  one-cycle pulse when an instruction completes
- halt_o  out  1  sticky, set on ECALL/EBREAK or illegal opcode
- illegal_o  out  1  sticky, set on illegal opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: req=1, addr=PC. In the cycle rvalid=1, latch the instruction into IR and go to DECODE.
- DECODE:
  - Drive raddr_a=IR[19:15] and raddr_b=IR[24:20].
  - Form the immediate (I/S/B/U/J) and latch rs1/rs2 data into A/B.
  - Illegal opcode → HALT with illegal_o=1. SYSTEM opcode (1110011) → HALT.
- EXEC: drive alu_ctrl_o and operands; latch alu_result_i into R.
  - R-type: A op B. ALU codes: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
  - OP-IMM: A op imm.
  - LOAD/STORE: A+imm. JAL: PC+imm. JALR: (A+imm)&~1. AUIPC: PC+imm. LUI: 0+imm.
  - BRANCH: internal comparator on A/B (beq/bne/blt/bge/bltu/bgeu); target PC+imm.
  - Next state: LOAD/STORE → MEM; all others → WB.
- MEM: req=1, addr=R, we=(STORE), wdata=B.
  - In the cycle rvalid=1: a load latches rdata and goes to WB; a store goes to WB.
- WB:
  - rf_we_o=1 for R, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, unless rd==0.
  - wdata: R for ALU ops; load data for LOAD; PC+4 for JAL/JALR.
  - PC ← target (jump, or branch taken), otherwise PC+4. retire_o=1. Next state FETCH.
- HALT: absorbing; all requests and strobes low. Exit only via res_i.

## Timing
- Reset values:
  - PC=RESET_PC, state FETCH.
  - All *_req_o, rf_we_o, dmem_we_o, retire_o, halt_o, illegal_o = 0.
  - Address/data/ctrl outputs = 0.
- Cycles with zero-wait memory (rvalid in the first request cycle):
  - ALU, branch and jump instructions: 4 cycles, FETCH→DECODE→EXEC→WB.
  - LOAD/STORE: 5 cycles.
  - Each memory wait cycle adds 1.
- retire_o is back-to-back at most every 4 cycles.
- A request stays asserted with address and data stable until rvalid. rvalid while req=0 is ignored.
- Reset mid-access drops req on the next edge. Memories share res_i, so no stale response is expected.
- imem_addr_o and PC wrap modulo 2^32.
- x0 write suppression applies only to rf_we_o; R is still computed.

## Configuration
- CORE_SEQ_MISALIGN_TRAP_EN defined:
  - A load/store address with [1:0]≠0 goes to HALT with illegal_o=1 instead of MEM.
  - A taken branch or jump target with [1:0]≠0 does the same, in WB, before the PC update.
- Undefined: address bits [1:0] are forced to 0 on dmem_addr_o and on the PC. No trap.

## Structure
- Package core_pkg holds:
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM).
  - 4-bit ALU code constants.
  - State enum.
- Sub-module imm_gen (IR → 32-bit sign-extended immediate, format selected by opcode). Everything else lives in core_sequencer.

## Test plan
- Reset with RESET_PC=32'h100 → imem_addr_o=32'h100, imem_req_o=1 on the first post-reset cycle; all strobes 0.
- Fetch addi x1,x0,5 (32'h00500093), zero-wait → rf_we_o=1, rf_waddr_o=1, rf_wdata_o=5 in cycle 4, retire_o=1 in the same cycle, PC=32'h104.
- add x0,x1,x1 → alu_ctrl_o=0000 in EXEC, rf_we_o stays 0 in WB, retire_o=1.
- beq x1,x1,+8 with 2 imem wait cycles → 6 cycles to retire, next imem_addr_o=PC+8. bne on the same operands → PC+4.
- sw x1,4(x2) with x2=32'h200, dmem rvalid after 3 cycles → dmem_addr_o=32'h204, dmem_we_o=1, dmem_wdata_o=5 held stable for 3 cycles, then lw returns 5.
- Illegal opcode 7'b1111111 → halt_o=1 and illegal_o=1 from the cycle after DECODE, no further requests. res_i in the middle of a dmem wait clears everything at the next edge.
